// File: rtl/l2_tag_array.sv
// l2_tag_array: N-way set-associative L2 tag store with tree-PLRU replacement.
// Single-cycle lookup (hit + victim), separate fill/dirty-update port, and a
// post-reset sweep that clears every set before accepting traffic.
// Optional feature macro: L2_TAG_PARITY_EN (per-way even parity over the tag).
module l2_tag_array #(
    parameter  int WAYS  = 4,
    parameter  int SETS  = 512,
    parameter  int TAG_W = 18,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_busy,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_index,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [WAY_W-1:0] rsp_hit_way,
    output logic             rsp_hit_dirty,
    output logic [WAY_W-1:0] rsp_victim_way,
    output logic             rsp_victim_valid,
    output logic             rsp_victim_dirty,
    output logic [TAG_W-1:0] rsp_victim_tag,
    output logic             rsp_perr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic [WAY_W-1:0] upd_way,
    input  logic             upd_fill,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic             upd_dirty,
    output logic             upd_done
);
    localparam int PL_W = WAYS - 1;

    typedef enum logic {S_INIT, S_IDLE} state_t;

    // Tree-PLRU (heap order): mark every node on the path to w as pointing away.
    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] b,
                                                   input logic [WAY_W-1:0] w);
        logic [WAYS-1:0]  t;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] wsh;
        logic             dir;
        t    = {1'b0, b};
        node = '0;
        wsh  = w;
        for (int l = 0; l < WAY_W; l++) begin
            dir     = wsh[WAY_W-1];
            wsh     = wsh << 1;
            t[node] = ~dir;
            node    = node + node + WAY_W'(1) + WAY_W'(dir);
        end
        return t[PL_W-1:0];
    endfunction

    // Tree-PLRU walk: follow node bits (0 = lower half, 1 = upper half).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] b);
        logic [WAYS-1:0]  t;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        logic             dir;
        t    = {1'b0, b};
        node = '0;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            dir  = t[node];
            way  = (way << 1) | WAY_W'(dir);
            node = node + node + WAY_W'(1) + WAY_W'(dir);
        end
        return way;
    endfunction

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     cnt;

    logic [WAYS-1:0]             valid_mem [SETS];
    logic [WAYS-1:0]             dirty_mem [SETS];
    logic [WAYS-1:0][TAG_W-1:0]  tag_mem   [SETS];
    logic [PL_W-1:0]             plru_mem  [SETS];

    logic [WAYS-1:0]             rd_valid, rd_dirty;
    logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
    logic [PL_W-1:0]             rd_plru;
    logic [TAG_W-1:0]            rd_req_tag;
    logic [IDX_W-1:0]            rd_index;
    logic                        vld_q;

    logic                        req_acc, upd_acc, init_we;
    logic [WAYS-1:0]             match, perr_way;
    logic                        hit;
    logic [WAY_W-1:0]            hit_way, victim;
    logic                        touch_we;
    logic [PL_W-1:0]             touch_val;

`ifdef L2_TAG_PARITY_EN
    logic [SETS-1:0][WAYS-1:0]   par_mem;
    logic [WAYS-1:0]             rd_par;
`endif

    // State register and sweep counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) cnt <= cnt + IDX_W'(1);
        end
    end

    // Next state: leave INIT once the last set has been cleared
    always_comb begin
        state_nxt = state;
        if (state == S_INIT && cnt == IDX_W'(SETS - 1)) state_nxt = S_IDLE;
    end

    // FSM outputs: updates take priority over a same-cycle lookup
    always_comb begin
        init_busy = rst || (state == S_INIT);
        init_we   = (state == S_INIT);
        req_ready = !rst && (state == S_IDLE) && !upd_valid;
        req_acc   = req_ready && req_valid;
        upd_acc   = !rst && (state == S_IDLE) && upd_valid;
    end

    // Array writes: sweep clear, hit touch, then update (update touch overrides)
    always_ff @(posedge clk) begin
        if (init_we) begin
            valid_mem[cnt] <= '0;
            dirty_mem[cnt] <= '0;
            plru_mem[cnt]  <= '0;
        end
        if (touch_we) plru_mem[rd_index] <= touch_val;
        if (upd_acc) begin
            dirty_mem[upd_index][upd_way] <= upd_dirty;
            if (upd_fill) begin
                valid_mem[upd_index][upd_way] <= 1'b1;
                tag_mem[upd_index][upd_way]   <= upd_tag;
                plru_mem[upd_index]           <= plru_touch(plru_mem[upd_index], upd_way);
`ifdef L2_TAG_PARITY_EN
                par_mem[upd_index][upd_way]   <= ^upd_tag;
`endif
            end
        end
    end

    // Synchronous read on accept; write-first bypass of a same-cycle hit touch
    always_ff @(posedge clk) begin
        if (req_acc) begin
            rd_valid   <= valid_mem[req_index];
            rd_dirty   <= dirty_mem[req_index];
            rd_tag     <= tag_mem[req_index];
            rd_plru    <= (touch_we && rd_index == req_index) ? touch_val : plru_mem[req_index];
            rd_req_tag <= req_tag;
            rd_index   <= req_index;
`ifdef L2_TAG_PARITY_EN
            rd_par     <= par_mem[req_index];
`endif
        end
    end

    // Response valid and update completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            vld_q    <= req_acc;
            upd_done <= upd_acc;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
`ifdef L2_TAG_PARITY_EN
        assign perr_way[w] = rd_valid[w] && ((^rd_tag[w]) != rd_par[w]);
`else
        assign perr_way[w] = 1'b0;
`endif
        assign match[w] = rd_valid[w] && !perr_way[w] && (rd_tag[w] == rd_req_tag);
    end

    // Hit (lowest matching way) and victim (invalid, then parity-bad, then PLRU)
    always_comb begin
        logic inv_found, perr_found;
        hit        = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        perr_found = 1'b0;
        victim     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!rd_valid[w]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (perr_way[w]) begin
                    perr_found = 1'b1;
                    victim     = WAY_W'(w);
                end
            end
            if (!perr_found) victim = plru_victim(rd_plru);
        end
        touch_val = plru_touch(rd_plru, hit_way);
        touch_we  = vld_q && hit && !(upd_acc && upd_fill && upd_index == rd_index);
    end

    // Response outputs, held at zero when no result is presented
    always_comb begin
        rsp_valid        = vld_q;
        rsp_hit          = vld_q && hit;
        rsp_hit_way      = vld_q ? hit_way : '0;
        rsp_hit_dirty    = vld_q && hit && rd_dirty[hit_way];
        rsp_victim_way   = vld_q ? victim : '0;
        rsp_victim_valid = vld_q && rd_valid[victim];
        rsp_victim_dirty = vld_q && rd_dirty[victim] && !perr_way[victim];
        rsp_victim_tag   = vld_q ? rd_tag[victim] : '0;
        rsp_perr         = vld_q && (|perr_way);
    end

endmodule
